lc3b_mem_arbiter: RTL and testbench
===================================

# lc3b_mem_arbiter

Two-to-one memory arbiter that sits directly downstream of `cpu_datapath`. It merges the pipeline's instruction-fetch port (`imem_*`) and data port (`dmem_*`) onto a single physical memory port (`pmem_*`). Each accepted request is registered, issued as one strobed bus transaction, retried on memory back-pressure, and answered with a registered one-cycle response. Data requests take priority; an alternation rule prevents instruction-fetch starvation.

## Interface
- `MAX_RETRY`, default 4: reissues of a data request after `pmem_retry` before the retry is reported to the datapath; legal range 1–15.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_address`  in  16  instruction fetch address (lc3b_word).
- `imem_stb`, `imem_cyc`  in  1  fetch request strobe and cycle-valid.
- `imem_rdata`  out  16  fetched word, registered.
- `imem_resp`  out  1  one-cycle fetch completion pulse.
- `dmem_address`, `dmem_wdata`  in  16  data address and store data.
- `dmem_stb`, `dmem_cyc`, `dmem_write`  in  1  data strobe, cycle-valid, and write enable.
- `dmem_byte_enable`  in  2  store byte mask (lc3b_mem_wmask).
- `dmem_rdata`  out  16  load data, registered.
- `dmem_resp`, `dmem_retry`  out  1  one-cycle completion pulse and one-cycle give-up pulse.
- `pmem_address`, `pmem_wdata`  out  16  physical memory address and write data.
- `pmem_stb`, `pmem_cyc`, `pmem_write`  out  1  physical memory strobe, cycle-valid, and write enable.
- `pmem_byte_enable`  out  2  physical memory byte mask.
- `pmem_rdata`  in  16  physical memory read data.
- `pmem_ack`, `pmem_retry`  in  1  transaction done; request refused, reissue.

## Operation
- A request is pending when `stb & cyc` on that port.
- States:
  - IDLE: all `pmem_*` low.
  - GRANT_I: instruction transaction in flight.
  - GRANT_D: data transaction in flight.
  - BACKOFF: one idle cycle after a retry.
  - RESP: response cycle.
- Arbitration in IDLE:
  - Only one port pending: grant that port.
  - Both pending: grant D, unless the previous completed grant was D. In that case grant I.
- On grant:
  - Capture address, wdata, write, and byte_enable into holding registers. `pmem_*` is driven only from these registers.
  - For I grants, `pmem_write`=0 and `pmem_byte_enable`=2'b00.
- `pmem_cyc` stays high from grant until ack or give-up, including through BACKOFF. `pmem_stb` is high in GRANT_* and low in BACKOFF.
- `pmem_ack` in GRANT_*:
  - Latch `pmem_rdata` into the granted port's rdata register and go to RESP.
  - RESP pulses the granted port's `resp` for one cycle, then returns to IDLE.
- `pmem_retry` in GRANT_*:
  - Increment the retry counter (4 bits, cleared on grant) and go to BACKOFF, then back to GRANT_*.
  - I grants retry without limit.
  - For a D grant, if the counter already equals `MAX_RETRY`: drop `pmem_cyc`, pulse `dmem_retry` for one cycle, and return to IDLE.
- `pmem_ack` and `pmem_retry` high together: ack wins and the counter is unchanged.
- Requester drops `cyc` mid-transaction (abort): the `pmem` transaction still runs to ack or give-up, and `resp` is suppressed. The alternation rule still records the grant.
- rdata registers hold their value until the next ack for that port.

## Timing
- Reset: asynchronous, active-low. All outputs are 0, state is IDLE, counters and alternation flag are 0, and holding and rdata registers are 0. Reset mid-transaction abandons it without any `resp`.
- A request seen in IDLE at edge N drives `pmem_stb`/`pmem_cyc` from cycle N+1.
- Ack sampled at edge M:
  - `resp` and valid rdata during cycle M+1.
  - IDLE at M+2.
  - Next `pmem_stb` no earlier than M+3.
  - Minimum latency is 3 cycles, request to `resp`.
- Retry at edge M: `pmem_stb` low for cycle M+1 and high again at M+2.
- `resp` and `dmem_retry` never assert in the same cycle. `imem_resp` and `dmem_resp` are never both high.
- The requester must hold `cyc`, `stb`, and all inputs until `resp` or `dmem_retry`. Changes after the grant cycle are ignored.

## Test plan
- Single fetch: `imem_address`=16'h0040, memory acks 2 cycles after the strobe with 16'h1234. Expect `imem_resp` for one cycle with `imem_rdata`=16'h1234, `pmem_write`=0, and 4-cycle latency.
- Simultaneous requests: I and D requests every cycle for 6 transactions. Expect pmem addresses in order D,I,D,I,D,I, and no port waits more than one transaction.
- Store with retry: `dmem_write`=1, addr 16'h2002, wdata 16'hBEEF, mask 2'b10. Memory retries twice, then acks. Expect `pmem_stb` low one cycle after each retry, `pmem_cyc` held high, identical address/data/mask on each reissue, and one `dmem_resp`.
- Give-up: memory retries continuously on a D load with `MAX_RETRY`=4. Expect exactly 5 strobes, then a one-cycle `dmem_retry`, `pmem_cyc` low, and no `dmem_resp`.
- Ack with retry: `pmem_ack` and `pmem_retry` asserted in the same cycle. Expect completion via RESP with no BACKOFF.
- Abort and reset: drop `imem_cyc` mid-transaction and expect no `imem_resp` while the `pmem` ack is still consumed. Assert `rst_n`=0 during GRANT_D and expect all outputs 0 asynchronously and IDLE on release.

Source files
------------

// File: rtl/lc3b_mem_arbiter_if.sv
// lc3b_mem_arbiter_if: fetch, data and physical memory buses that meet
// at the memory arbiter, bundled so the arbiter takes a single bus port.
interface lc3b_mem_arbiter_if;
    logic [15:0] imem_address;
    logic        imem_stb;
    logic        imem_cyc;
    logic [15:0] imem_rdata;
    logic        imem_resp;

    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic        dmem_stb;
    logic        dmem_cyc;
    logic        dmem_write;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_retry;

    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic        pmem_stb;
    logic        pmem_cyc;
    logic        pmem_write;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata;
    logic        pmem_ack;
    logic        pmem_retry;

    // Arbiter side: serves the datapath, masters the physical memory.
    modport master (
        input  imem_address, imem_stb, imem_cyc,
        input  dmem_address, dmem_wdata, dmem_stb, dmem_cyc,
        input  dmem_write, dmem_byte_enable,
        input  pmem_rdata, pmem_ack, pmem_retry,
        output imem_rdata, imem_resp,
        output dmem_rdata, dmem_resp, dmem_retry,
        output pmem_address, pmem_wdata, pmem_stb, pmem_cyc,
        output pmem_write, pmem_byte_enable
    );

    // Environment side: datapath requesters plus the memory itself.
    modport slave (
        output imem_address, imem_stb, imem_cyc,
        output dmem_address, dmem_wdata, dmem_stb, dmem_cyc,
        output dmem_write, dmem_byte_enable,
        output pmem_rdata, pmem_ack, pmem_retry,
        input  imem_rdata, imem_resp,
        input  dmem_rdata, dmem_resp, dmem_retry,
        input  pmem_address, pmem_wdata, pmem_stb, pmem_cyc,
        input  pmem_write, pmem_byte_enable
    );
endinterface

// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: merges instruction fetch and data ports onto one
// physical memory port with data priority, fetch alternation and retry.
module lc3b_mem_arbiter #(
    parameter int unsigned MAX_RETRY = 4
) (
    input logic                clk,
    input logic                rst_n,
    lc3b_mem_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        BACKOFF,
        RESP
    } state_t;

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] irdata_q, irdata_d;
    logic [15:0] drdata_q, drdata_d;
    logic        sel_q, sel_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic        resp_ok_q, resp_ok_d;
    logic        dretry_q, dretry_d;

    logic i_req;
    logic d_req;
    logic own_cyc;
    logic busy;
    logic strobe;

    // A data requester that was just given up on still holds its strobe
    // during the dmem_retry cycle; masking it avoids an instant regrant.
    assign i_req   = bus.imem_stb & bus.imem_cyc;
    assign d_req   = bus.dmem_stb & bus.dmem_cyc & ~dretry_q;
    assign own_cyc = sel_q ? bus.dmem_cyc : bus.imem_cyc;

    assign strobe = (state_q == GRANT_I) | (state_q == GRANT_D);
    assign busy   = strobe | (state_q == BACKOFF);

    assign bus.pmem_stb         = strobe;
    assign bus.pmem_cyc         = busy;
    assign bus.pmem_address     = busy ? addr_q  : '0;
    assign bus.pmem_wdata       = busy ? wdata_q : '0;
    assign bus.pmem_write       = busy & write_q;
    assign bus.pmem_byte_enable = busy ? be_q    : '0;

    assign bus.imem_rdata = irdata_q;
    assign bus.dmem_rdata = drdata_q;
    assign bus.imem_resp  = (state_q == RESP) & resp_ok_q & ~sel_q;
    assign bus.dmem_resp  = (state_q == RESP) & resp_ok_q & sel_q;
    assign bus.dmem_retry = dretry_q;

    // Next-state: arbitration, capture, retry/backoff and completion.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        be_d      = be_q;
        irdata_d  = irdata_q;
        drdata_d  = drdata_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        resp_ok_d = resp_ok_q;
        dretry_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req && !(i_req && last_q)) begin
                    state_d = GRANT_D;
                    sel_d   = 1'b1;
                    last_d  = 1'b1;
                    addr_d  = bus.dmem_address;
                    wdata_d = bus.dmem_wdata;
                    write_d = bus.dmem_write;
                    be_d    = bus.dmem_byte_enable;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end else if (i_req) begin
                    state_d = GRANT_I;
                    sel_d   = 1'b0;
                    last_d  = 1'b0;
                    addr_d  = bus.imem_address;
                    wdata_d = '0;
                    write_d = 1'b0;
                    be_d    = '0;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end
            end

            GRANT_I, GRANT_D: begin
                abort_d = abort_q | ~own_cyc;
                if (bus.pmem_ack) begin
                    state_d   = RESP;
                    resp_ok_d = ~abort_q & own_cyc;
                    if (sel_q) begin
                        drdata_d = bus.pmem_rdata;
                    end else begin
                        irdata_d = bus.pmem_rdata;
                    end
                end else if (bus.pmem_retry) begin
                    if (sel_q && (cnt_q == RETRY_LIMIT)) begin
                        state_d  = IDLE;
                        dretry_d = 1'b1;
                    end else begin
                        state_d = BACKOFF;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end

            BACKOFF: begin
                abort_d = abort_q | ~own_cyc;
                state_d = sel_q ? GRANT_D : GRANT_I;
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and holding registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            be_q      <= '0;
            irdata_q  <= '0;
            drdata_q  <= '0;
            sel_q     <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            resp_ok_q <= 1'b0;
            dretry_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            be_q      <= be_d;
            irdata_q  <= irdata_d;
            drdata_q  <= drdata_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            resp_ok_q <= resp_ok_d;
            dretry_q  <= dretry_d;
        end
    end

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// tb_lc3b_mem_arbiter: directed scenarios with a response scoreboard
// and a physical-bus strobe scoreboard driven by a scripted memory.
module tb_lc3b_mem_arbiter;

    localparam int BUDGET = 60;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    int mem_wait    = 0;
    int mem_retries = 0;
    bit mem_forever = 1'b0;
    bit mem_both    = 1'b0;

    typedef struct {
        int          kind;
        logic [15:0] data;
        int          req_cyc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        wr;
        logic [1:0]  be;
        bit          w_valid;
    } stb_t;

    rsp_t rsp_q[$];
    stb_t stb_q[$];

    lc3b_mem_arbiter_if bus();

    lc3b_mem_arbiter #(.MAX_RETRY(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return (a == 16'h0040) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    task automatic check(input string name, input logic [47:0] act,
                         input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_stb(input logic [15:0] a, input logic [15:0] w,
                           input logic wr, input logic [1:0] be,
                           input bit wv);
        stb_t s;
        s.addr = a; s.wdata = w; s.wr = wr; s.be = be; s.w_valid = wv;
        stb_q.push_back(s);
    endtask

    task automatic exp_rsp(input int kind, input logic [15:0] d,
                           input int lat);
        rsp_t r;
        r.kind = kind; r.data = d; r.req_cyc = cycle; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    task automatic i_run(input logic [15:0] a);
        int n;
        bus.imem_address = a;
        bus.imem_stb = 1'b1;
        bus.imem_cyc = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.imem_resp && n < BUDGET);
        checks++;
        if (!bus.imem_resp) begin
            errors++;
            $display("FAIL imem_wait: no imem_resp in %0d cycles, expected one", n);
        end
    endtask

    task automatic i_idle();
        bus.imem_stb = 1'b0;
        bus.imem_cyc = 1'b0;
    endtask

    task automatic d_run(input logic [15:0] a, input logic [15:0] w,
                         input logic wr, input logic [1:0] be);
        int n;
        bus.dmem_address = a;
        bus.dmem_wdata = w;
        bus.dmem_write = wr;
        bus.dmem_byte_enable = be;
        bus.dmem_stb = 1'b1;
        bus.dmem_cyc = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.dmem_resp || bus.dmem_retry) && n < BUDGET);
        checks++;
        if (!(bus.dmem_resp || bus.dmem_retry)) begin
            errors++;
            $display("FAIL dmem_wait: no dmem_resp/retry in %0d cycles, expected one", n);
        end
    endtask

    task automatic d_idle();
        bus.dmem_stb = 1'b0;
        bus.dmem_cyc = 1'b0;
        bus.dmem_write = 1'b0;
    endtask

    // Scripted memory: optional wait states, N retries or endless retry,
    // and optionally ack together with retry.
    initial begin : mem_model
        int w;
        w = 0;
        bus.pmem_ack = 1'b0;
        bus.pmem_retry = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.pmem_ack = 1'b0;
            bus.pmem_retry = 1'b0;
            bus.pmem_rdata = '0;
            if (bus.pmem_stb) begin
                if (w < mem_wait) begin
                    w++;
                end else begin
                    w = 0;
                    if (mem_forever || mem_retries > 0) begin
                        bus.pmem_retry = 1'b1;
                        if (mem_retries > 0) mem_retries--;
                    end else begin
                        bus.pmem_ack = 1'b1;
                        bus.pmem_retry = mem_both;
                        bus.pmem_rdata = mem_data(bus.pmem_address);
                    end
                end
            end else begin
                w = 0;
            end
        end
    end

    // Response scoreboard: every resp/retry pulse pops one expectation.
    initial begin : rsp_mon
        int   k;
        int   lat;
        rsp_t e;
        logic [15:0] d;
        forever begin
            @(negedge clk);
            k = -1;
            if (bus.imem_resp) k = 0;
            else if (bus.dmem_resp) k = 1;
            else if (bus.dmem_retry) k = 2;
            if (k >= 0) begin
                checks++;
                if ((bus.imem_resp && bus.dmem_resp) ||
                    ((bus.imem_resp || bus.dmem_resp) && bus.dmem_retry)) begin
                    errors++;
                    $display("FAIL exclusive: ir=%b dr=%b dretry=%b, expected one high",
                             bus.imem_resp, bus.dmem_resp, bus.dmem_retry);
                end
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL response: unexpected kind %0d at cycle %0d, expected none",
                             k, cycle);
                end else begin
                    e = rsp_q.pop_front();
                    if (e.kind != k) begin
                        errors++;
                        $display("FAIL rsp_kind: got %0d expected %0d", k, e.kind);
                    end else if (k != 2) begin
                        d = (k == 0) ? bus.imem_rdata : bus.dmem_rdata;
                        checks++;
                        if (d !== e.data) begin
                            errors++;
                            $display("FAIL rsp_data: got %h expected %h", d, e.data);
                        end
                    end
                    if (e.lat > 0) begin
                        lat = cycle - e.req_cyc + 1;
                        checks++;
                        if (lat != e.lat) begin
                            errors++;
                            $display("FAIL latency: got %0d expected %0d", lat, e.lat);
                        end
                    end
                end
            end
        end
    end

    // Strobe scoreboard plus backoff shape after each refused strobe.
    initial begin : pmem_mon
        bit   prev_stb;
        bit   retry_last;
        bit   backoff_last;
        stb_t e;
        prev_stb = 1'b0;
        retry_last = 1'b0;
        backoff_last = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (backoff_last) begin
                checks++;
                if (bus.pmem_stb !== 1'b1) begin
                    errors++;
                    $display("FAIL reissue_stb: got %b expected 1", bus.pmem_stb);
                end
            end
            backoff_last = 1'b0;
            if (retry_last) begin
                checks++;
                if (bus.pmem_stb !== 1'b0) begin
                    errors++;
                    $display("FAIL backoff_stb: got %b expected 0", bus.pmem_stb);
                end
                checks++;
                if (bus.pmem_cyc === bus.dmem_retry) begin
                    errors++;
                    $display("FAIL backoff_cyc: cyc=%b dmem_retry=%b, expected cyc=~dmem_retry",
                             bus.pmem_cyc, bus.dmem_retry);
                end
                backoff_last = bus.pmem_cyc;
            end
            if (bus.pmem_stb && !prev_stb) begin
                checks++;
                if (stb_q.size() == 0) begin
                    errors++;
                    $display("FAIL pmem_strobe: unexpected strobe addr %h, expected none",
                             bus.pmem_address);
                end else begin
                    e = stb_q.pop_front();
                    if (bus.pmem_address !== e.addr || bus.pmem_write !== e.wr ||
                        bus.pmem_byte_enable !== e.be ||
                        (e.w_valid && bus.pmem_wdata !== e.wdata)) begin
                        errors++;
                        $display("FAIL pmem_strobe: got a=%h w=%h we=%b be=%b expected a=%h w=%h we=%b be=%b",
                                 bus.pmem_address, bus.pmem_wdata, bus.pmem_write,
                                 bus.pmem_byte_enable, e.addr, e.wdata, e.wr, e.be);
                    end
                end
            end
            retry_last = bus.pmem_stb && bus.pmem_retry && !bus.pmem_ack;
            prev_stb = bus.pmem_stb;
        end
    end

    initial begin : stim
        int n;
        rst_n = 1'b0;
        bus.imem_address = '0;
        bus.imem_stb = 1'b0;
        bus.imem_cyc = 1'b0;
        bus.dmem_address = '0;
        bus.dmem_wdata = '0;
        bus.dmem_stb = 1'b0;
        bus.dmem_cyc = 1'b0;
        bus.dmem_write = 1'b0;
        bus.dmem_byte_enable = '0;
        repeat (2) @(negedge clk);
        check("reset_rdata", 48'({bus.imem_rdata, bus.dmem_rdata}), 48'h0);
        check("reset_pmem", 48'({bus.pmem_address, bus.pmem_wdata, bus.pmem_stb,
              bus.pmem_cyc, bus.pmem_write, bus.pmem_byte_enable}), 48'h0);
        check("reset_flags", 48'({bus.imem_resp, bus.dmem_resp, bus.dmem_retry}), 48'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single fetch, one wait state.
        mem_wait = 1;
        exp_stb(16'h0040, 16'h0000, 1'b0, 2'b00, 1'b0);
        exp_rsp(0, 16'h1234, 4);
        i_run(16'h0040);
        i_idle();
        mem_wait = 0;
        repeat (3) @(negedge clk);

        // Both ports busy: strict D,I alternation.
        exp_stb(16'h2000, 16'h0000, 1'b0, 2'b00, 1'b1);
        exp_stb(16'h0100, 16'h0000, 1'b0, 2'b00, 1'b0);
        exp_stb(16'h2010, 16'h0000, 1'b0, 2'b00, 1'b1);
        exp_stb(16'h0102, 16'h0000, 1'b0, 2'b00, 1'b0);
        exp_stb(16'h2020, 16'h0000, 1'b0, 2'b00, 1'b1);
        exp_stb(16'h0104, 16'h0000, 1'b0, 2'b00, 1'b0);
        exp_rsp(1, 16'h7A5A, -1);
        exp_rsp(0, 16'h5B5A, -1);
        exp_rsp(1, 16'h7A4A, -1);
        exp_rsp(0, 16'h5B58, -1);
        exp_rsp(1, 16'h7A7A, -1);
        exp_rsp(0, 16'h5B5E, -1);
        fork
            begin
                i_run(16'h0100);
                i_run(16'h0102);
                i_run(16'h0104);
                i_idle();
            end
            begin
                d_run(16'h2000, 16'h0000, 1'b0, 2'b00);
                d_run(16'h2010, 16'h0000, 1'b0, 2'b00);
                d_run(16'h2020, 16'h0000, 1'b0, 2'b00);
                d_idle();
            end
        join
        repeat (3) @(negedge clk);

        // Store refused twice, then accepted.
        mem_retries = 2;
        repeat (3) exp_stb(16'h2002, 16'hBEEF, 1'b1, 2'b10, 1'b1);
        exp_rsp(1, 16'h7A58, 7);
        d_run(16'h2002, 16'hBEEF, 1'b1, 2'b10);
        d_idle();
        repeat (3) @(negedge clk);

        // Endless refusal: five strobes then give up.
        mem_forever = 1'b1;
        repeat (5) exp_stb(16'h3000, 16'h1111, 1'b0, 2'b11, 1'b1);
        exp_rsp(2, 16'h0000, -1);
        d_run(16'h3000, 16'h1111, 1'b0, 2'b11);
        check("giveup_cyc", 48'(bus.pmem_cyc), 48'h0);
        check("giveup_rdata_hold", 48'(bus.dmem_rdata), 48'h7A58);
        d_idle();
        mem_forever = 1'b0;
        repeat (3) @(negedge clk);

        // Ack and retry together: ack wins, no backoff.
        mem_both = 1'b1;
        exp_stb(16'h2040, 16'h0000, 1'b0, 2'b00, 1'b1);
        exp_rsp(1, 16'h7A1A, 3);
        d_run(16'h2040, 16'h0000, 1'b0, 2'b00);
        d_idle();
        mem_both = 1'b0;
        repeat (3) @(negedge clk);

        // Fetch abandoned by the requester mid-transaction.
        mem_wait = 3;
        exp_stb(16'h0200, 16'h0000, 1'b0, 2'b00, 1'b0);
        bus.imem_address = 16'h0200;
        bus.imem_stb = 1'b1;
        bus.imem_cyc = 1'b1;
        @(negedge clk);
        check("abort_granted", 48'(bus.pmem_stb), 48'h1);
        i_idle();
        n = 0;
        while (bus.pmem_cyc && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("abort_done", 48'(bus.pmem_cyc), 48'h0);
        repeat (4) @(negedge clk);
        check("abort_rdata", 48'(bus.imem_rdata), 48'h585A);
        mem_wait = 0;

        // Reset while a store is in flight.
        mem_wait = 5;
        exp_stb(16'h4000, 16'h5555, 1'b1, 2'b01, 1'b1);
        bus.dmem_address = 16'h4000;
        bus.dmem_wdata = 16'h5555;
        bus.dmem_write = 1'b1;
        bus.dmem_byte_enable = 2'b01;
        bus.dmem_stb = 1'b1;
        bus.dmem_cyc = 1'b1;
        @(negedge clk);
        check("rst_granted", 48'({bus.pmem_stb, bus.pmem_cyc}), 48'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_pmem", 48'({bus.pmem_address, bus.pmem_wdata, bus.pmem_stb,
              bus.pmem_cyc, bus.pmem_write, bus.pmem_byte_enable}), 48'h0);
        check("rst_async_rdata", 48'({bus.imem_rdata, bus.dmem_rdata}), 48'h0);
        check("rst_async_flags", 48'({bus.imem_resp, bus.dmem_resp, bus.dmem_retry}), 48'h0);
        @(negedge clk);
        d_idle();
        @(negedge clk);
        rst_n = 1'b1;
        mem_wait = 0;
        repeat (2) @(negedge clk);
        check("rst_release_idle", 48'({bus.pmem_stb, bus.pmem_cyc}), 48'h0);

        // Normal fetch after reset, minimum latency.
        exp_stb(16'h0060, 16'h0000, 1'b0, 2'b00, 1'b0);
        exp_rsp(0, 16'h5A3A, 3);
        i_run(16'h0060);
        i_idle();
        repeat (4) @(negedge clk);

        check("rsp_queue_empty", 48'(rsp_q.size()), 48'h0);
        check("stb_queue_empty", 48'(stb_q.size()), 48'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
